audio_tone_gen: RTL

Parametrised multi-channel audio sample source for the HDMI audio path, in the pixel clock domain. A fractional-rate strobe generator produces an exact long-term SAMPLE_RATE from any CLK_HZ, replacing fixed divide-by-N counters. Per-channel phase-accumulator oscillators produce saw, square or triangle waves with runtime pitch and attenuation. Samples go to the HDMI packetiser over a valid/ready handshake with overrun detection.

---
 rtl/audio_pkg.sv | 13 +
 rtl/audio_rate_strobe.sv | 48 ++++
 rtl/audio_tone_gen.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio tone generator and its rate strobe.
package audio_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SILENT = 2'd3
    } wave_mode_e;

    localparam int ATTEN_WIDTH = 4;

endpackage

// File: rtl/audio_rate_strobe.sv
// Fractional-rate strobe: emits exactly SAMPLE_RATE one-cycle pulses per CLK_HZ enabled cycles.
module audio_rate_strobe #(
    parameter int CLK_HZ      = 25_200_000,
    parameter int SAMPLE_RATE = 48000
) (
    input  logic clk_pixel,
    input  logic resetn,
    input  logic enable,
    output logic strobe
);

    localparam int AW = $clog2(CLK_HZ) + 1;
    localparam int SW = AW + 1;
    localparam logic [SW-1:0] RATE_S = SW'(SAMPLE_RATE);
    localparam logic [SW-1:0] CLK_S  = SW'(CLK_HZ);

    logic [AW-1:0] acc_q, acc_d;
    logic          strobe_q, strobe_d;
    logic [SW-1:0] acc_sum;

    always_comb begin
        acc_sum  = {1'b0, acc_q} + RATE_S;
        acc_d    = acc_q;
        strobe_d = 1'b0;
        if (enable) begin
            // Wrapping past CLK_HZ is a sample tick; the remainder carries the fraction.
            if (acc_sum >= CLK_S) begin
                acc_d    = AW'(acc_sum - CLK_S);
                strobe_d = 1'b1;
            end else begin
                acc_d = AW'(acc_sum);
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!resetn) begin
            acc_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/audio_tone_gen.sv
// Multi-channel phase-accumulator tone source with valid/ready output and overrun flag.
// Define AUDIO_MIX_EN to add the saturated mono_data mix output.
module audio_tone_gen
    import audio_pkg::*;
#(
    parameter int CLK_HZ      = 25_200_000,
    parameter int SAMPLE_RATE = 48000,
    parameter int BIT_WIDTH   = 16,
    parameter int CHANNELS    = 2,
    parameter int PHASE_WIDTH = 24
) (
    input  logic                              clk_pixel,
    input  logic                              resetn,
    input  logic                              enable,
    input  logic [CHANNELS*PHASE_WIDTH-1:0]   phase_inc,
    input  logic [CHANNELS*2-1:0]             wave_mode,
    input  logic [CHANNELS*ATTEN_WIDTH-1:0]   atten,
    output logic                              sample_strobe,
    output logic                              sample_valid,
    input  logic                              sample_ready,
    output logic [CHANNELS*BIT_WIDTH-1:0]     sample_data,
    output logic                              overrun
`ifdef AUDIO_MIX_EN
    ,
    output logic [BIT_WIDTH-1:0]              mono_data
`endif
);

    localparam int BW = BIT_WIDTH;
    localparam int PW = PHASE_WIDTH;
    localparam logic [BW-1:0] WAVE_SIGN = {1'b1, {(BW-1){1'b0}}};
    localparam logic [BW-1:0] WAVE_MAX  = ~WAVE_SIGN;

    logic                       strobe;
    logic                       load_q, load_d;
    logic                       load_accept;
    logic                       valid_q, valid_d;
    logic                       overrun_q, overrun_d;
    logic [CHANNELS*BW-1:0]     data_q, data_d;
    logic [CHANNELS*BW-1:0]     samp_all;

    audio_rate_strobe #(
        .CLK_HZ      (CLK_HZ),
        .SAMPLE_RATE (SAMPLE_RATE)
    ) u_rate (
        .clk_pixel (clk_pixel),
        .resetn    (resetn),
        .enable    (enable),
        .strobe    (strobe)
    );

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [PW-1:0]          phase_q, phase_d;
            logic [PW-1:0]          inc_q, inc_d;
            wave_mode_e             mode_q, mode_d;
            logic [ATTEN_WIDTH-1:0] atten_q, atten_d;
            logic [BW-1:0]          top_bits, tri_bits;
            logic signed [BW-1:0]   wave;

            // Controls are captured on the tick; the phase steps on the following load cycle.
            always_comb begin
                phase_d = phase_q;
                inc_d   = inc_q;
                mode_d  = mode_q;
                atten_d = atten_q;
                if (strobe) begin
                    inc_d   = phase_inc[gi*PW +: PW];
                    mode_d  = wave_mode_e'(wave_mode[gi*2 +: 2]);
                    atten_d = atten[gi*ATTEN_WIDTH +: ATTEN_WIDTH];
                end
                if (load_q) begin
                    phase_d = phase_q + inc_q;
                end
            end

            always_comb begin
                top_bits = phase_q[PW-1 -: BW];
                tri_bits = phase_q[PW-2 -: BW];
                case (mode_q)
                    WAVE_SAW:    wave = top_bits ^ WAVE_SIGN;
                    WAVE_SQUARE: wave = phase_q[PW-1] ? WAVE_SIGN : WAVE_MAX;
                    WAVE_TRI:    wave = (phase_q[PW-1] ? ~tri_bits : tri_bits) ^ WAVE_SIGN;
                    default:     wave = '0;
                endcase
            end

            assign samp_all[gi*BW +: BW] = wave >>> atten_q;

            always_ff @(posedge clk_pixel) begin
                if (!resetn) begin
                    phase_q <= '0;
                    inc_q   <= '0;
                    mode_q  <= WAVE_SAW;
                    atten_q <= '0;
                end else begin
                    phase_q <= phase_d;
                    inc_q   <= inc_d;
                    mode_q  <= mode_d;
                    atten_q <= atten_d;
                end
            end
        end
    endgenerate

    // A new sample is dropped only when the held one is still unconsumed.
    assign load_accept = load_q && !(valid_q && !sample_ready);

    always_comb begin
        load_d    = strobe;
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        if (load_q) begin
            if (load_accept) begin
                valid_d = 1'b1;
                data_d  = samp_all;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!resetn) begin
            load_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            load_q    <= load_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample_strobe = strobe;
    assign sample_valid  = valid_q;
    assign sample_data   = data_q;
    assign overrun       = overrun_q;

`ifdef AUDIO_MIX_EN
    localparam int MW = BW + $clog2(CHANNELS);
    localparam logic signed [MW-1:0] MIX_MAX = {{(MW-BW+1){1'b0}}, {(BW-1){1'b1}}};
    localparam logic signed [MW-1:0] MIX_MIN = {{(MW-BW+1){1'b1}}, {(BW-1){1'b0}}};

    logic signed [MW-1:0] mix_sum;
    logic [BW-1:0]        mix_sat;
    logic [BW-1:0]        mono_q, mono_d;

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mix_sum = mix_sum + MW'($signed(samp_all[i*BW +: BW]));
        end
        if (mix_sum > MIX_MAX) begin
            mix_sat = WAVE_MAX;
        end else if (mix_sum < MIX_MIN) begin
            mix_sat = WAVE_SIGN;
        end else begin
            mix_sat = mix_sum[BW-1:0];
        end
        mono_d = load_accept ? mix_sat : mono_q;
    end

    always_ff @(posedge clk_pixel) begin
        if (!resetn) begin
            mono_q <= '0;
        end else begin
            mono_q <= mono_d;
        end
    end

    assign mono_data = mono_q;
`endif

endmodule
